divide_seq_unit: RTL and testbench

- Multi-cycle integer divider for the VCPU-32 execute stage.
- Inverse of the add datapath: each step is a trial subtraction done as an add of the inverted divisor with carry-in 1, using the same carry-lookahead adder structure.
- Produces one quotient bit per clock for signed or unsigned 32-bit operands.
- Start/done handshake with the pipeline control; the pipeline stalls while busy is high.

---
 rtl/divide_seq_unit.sv | 131 +++++++++++++
 tb/tb_divide_seq_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/divide_seq_unit.sv
// Multi-cycle restoring integer divider for the VCPU-32 execute stage.
// One quotient bit per clock; signed or unsigned operands; start/done handshake.
module divide_seq_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signedOp,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  output logic             busy,
  output logic             done,
  output logic [0:WIDTH-1] q,
  output logic [0:WIDTH-1] r,
  output logic             divZero,
  output logic             ovl
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [0:WIDTH-1] ALL_ONES = '1;
  localparam logic [0:WIDTH-1] MIN_NEG = {1'b1, (WIDTH-1)'(0)};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [0:WIDTH-1] dvd;
  logic [0:WIDTH-1] dvs;
  logic [0:WIDTH-1] rem;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;

  logic             is_zero;
  logic             is_ovf;
  logic [0:WIDTH-1] a_mag;
  logic [0:WIDTH-1] b_mag;
  logic [0:WIDTH-1] rem_sh;
  logic [0:WIDTH]   sum;
  logic             no_borrow;

  // Special-case detection and operand magnitudes at the sampling edge
  assign is_zero = (b == '0);
  assign is_ovf  = signedOp && (a == MIN_NEG) && (b == ALL_ONES);
  assign a_mag   = (signedOp && a[0]) ? -a : a;
  assign b_mag   = (signedOp && b[0]) ? -b : b;

  // Trial subtraction as add of inverted divisor with carry-in 1.
  // The bit shifted out of rem is an implicit 33rd bit: if set, the shifted
  // remainder exceeds any WIDTH-bit divisor, so the step never borrows.
  assign rem_sh    = {rem[1:WIDTH-1], dvd[0]};
  assign sum       = {1'b0, rem_sh} + {1'b0, ~dvs} + (WIDTH+1)'(1);
  assign no_borrow = sum[0] | rem[0];

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (is_zero || is_ovf) ? DONE : CALC;
      CALC: if (cnt == LAST_STEP) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      q       <= '0;
      r       <= '0;
      divZero <= 1'b0;
      ovl     <= 1'b0;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == CALC) || (state_nxt == FIX);
      done  <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            divZero <= 1'b0;
            ovl     <= 1'b0;
            if (is_zero) begin
              q       <= ALL_ONES;
              r       <= a;
              divZero <= 1'b1;
            end else if (is_ovf) begin
              q   <= MIN_NEG;
              r   <= '0;
              ovl <= 1'b1;
            end else begin
              dvd   <= a_mag;
              dvs   <= b_mag;
              neg_r <= signedOp & a[0];
              neg_q <= signedOp & (a[0] ^ b[0]);
              rem   <= '0;
              cnt   <= '0;
            end
          end
        end
        CALC: begin
          rem <= no_borrow ? sum[1:WIDTH] : rem_sh;
          dvd <= {dvd[1:WIDTH-1], no_borrow};
          cnt <= (cnt == LAST_STEP) ? '0 : cnt + CW'(1);
        end
        FIX: begin
          q <= neg_q ? -dvd : dvd;
          r <= neg_r ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_seq_unit.sv
// Self-checking bench for divide_seq_unit: directed vector table, hand-written
// multi-cycle sequences, and random operations against an arithmetic model.
module tb_divide_seq_unit;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          signedOp;
  logic [0:W-1]  a;
  logic [0:W-1]  b;
  logic          busy;
  logic          done;
  logic [0:W-1]  q;
  logic [0:W-1]  r;
  logic          divZero;
  logic          ovl;

  int n_cmp = 0;
  int n_bad = 0;

  divide_seq_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signedOp(signedOp),
    .a(a), .b(b), .busy(busy), .done(done), .q(q), .r(r),
    .divZero(divZero), .ovl(ovl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
    int          k;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic plus the two special cases
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic ms,
                       output logic [31:0] eq, output logic [31:0] er,
                       output logic edz, output logic eov, output int ek);
    longint sa, sb;
    edz = 1'b0; eov = 1'b0; ek = 33;
    if (mb == 32'd0) begin
      eq = 32'hFFFFFFFF; er = ma; edz = 1'b1; ek = 0;
    end else if (ms && ma == 32'h80000000 && mb == 32'hFFFFFFFF) begin
      eq = 32'h80000000; er = 32'd0; eov = 1'b1; ek = 0;
    end else if (ms) begin
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      eq = 32'(sa / sb);
      er = 32'(sa % sb);
    end else begin
      eq = ma / mb;
      er = ma % mb;
    end
  endtask

  // Issue one operation, wait for done, check timing and results.
  // k counts edges after the sampling edge E0 at which done is first seen.
  task automatic run_op(input string nm, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic ts, input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input logic eov, input int ek);
    int k, bc;
    @(negedge clk);
    a = ta; b = tb_; signedOp = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; signedOp = 1'($urandom);
    k = 0; bc = 0;
    while (!done && k < 60) begin
      if (busy) bc++;
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({nm, "_latency"}, 32'(k), 32'(ek));
    chk({nm, "_busy_cycles"}, 32'(bc), (ek == 0) ? 32'd0 : 32'd33);
    chk({nm, "_q"}, q, eq);
    chk({nm, "_r"}, r, er);
    chk({nm, "_divZero"}, 32'(divZero), 32'(edz));
    chk({nm, "_ovl"}, 32'(ovl), 32'(eov));
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, 32'(done), 32'd0);
    chk({nm, "_q_hold"}, q, eq);
    chk({nm, "_r_hold"}, r, er);
  endtask

  initial begin
    vec_t tbl[9];
    logic [31:0] eq, er, ra, rb;
    logic        edz, eov, rs;
    int          ek, k;
    bit          seen_done;

    tbl[0] = '{32'd100,      32'd7,        1'b0, 32'h0000000E, 32'd2,        1'b0, 1'b0, 33};
    tbl[1] = '{32'hFFFFFF9C, 32'd7,        1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 33};
    tbl[2] = '{32'd100,      32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2,        1'b0, 1'b0, 33};
    tbl[3] = '{32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 32'd5,        1'b1, 1'b0, 0};
    tbl[4] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, 1'b1, 0};
    tbl[5] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 1'b0, 1'b0, 33};
    tbl[6] = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 33};
    tbl[7] = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0, 33};
    tbl[8] = '{32'hFFFFFFFB, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1'b0, 0};

    rst = 1'b0; start = 1'b0; signedOp = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_q", q, 32'd0);
    chk("reset_r", r, 32'd0);
    chk("reset_divZero", 32'(divZero), 32'd0);
    chk("reset_ovl", 32'(ovl), 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s,
             tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov, tbl[i].k);
    end

    // Second start during CALC must be ignored and not queued
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'd1; signedOp = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; k = 0;
    repeat (10) begin @(posedge clk); #1; k++; end
    @(negedge clk);
    a = 32'd9; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; k++;
    while (!done && k < 60) begin @(posedge clk); #1; k++; end
    chk("ignore_start_latency", 32'(k), 32'd33);
    chk("ignore_start_q", q, 32'hFFFFFFFF);
    chk("ignore_start_r", r, 32'd0);
    @(posedge clk); #1;
    chk("ignore_start_not_queued", 32'(busy), 32'd0);

    // Reset during CALC step 15 discards the operation
    @(negedge clk);
    a = 32'd1000; b = 32'd3; signedOp = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_q", q, 32'd0);
    chk("midreset_r", r, 32'd0);
    chk("midreset_flags", {30'd0, divZero, ovl}, 32'd0);
    @(negedge clk); rst = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) seen_done = 1'b1; end
    chk("midreset_no_done", 32'(seen_done), 32'd0);
    run_op("after_reset_81_9", 32'd81, 32'd9, 1'b0, 32'd9, 32'd0, 1'b0, 1'b0, 33);

    // Random operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = $urandom_range(1, 15);
        3: rb = -$urandom_range(1, 15);
        4: ra = $urandom_range(0, 1000);
        default: ;
      endcase
      model(ra, rb, rs, eq, er, edz, eov, ek);
      run_op($sformatf("rand%0d", i), ra, rb, rs, eq, er, edz, eov, ek);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
